// File: rtl/cvt_fpi_sched_pkg.sv
// cvt_fpi_sched_pkg: shared format bit positions, defaults and pipeline stage record
package cvt_fpi_sched_pkg;
  localparam int FMT_SGL = 0;
  localparam int FMT_DBL = 1;
  localparam int FMT_EXT = 2;
  localparam int FMT_VRB = 3;
  localparam int DEF_NREQ = 3;
  localparam int DEF_LAT = 2;
  localparam int DEF_TAGW = 9;
  localparam int OPW = 82;
  localparam int RESW = 65;
  typedef struct packed {
    logic       valid;
    logic [1:0] port;
    logic       err;
  } stg_t;
endpackage

// File: rtl/cvt_rr_arb.sv
// cvt_rr_arb: round-robin pick of the first request at or after ptr, wrapping modulo N
module cvt_rr_arb #(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   ptr,
  output logic [N-1:0] gnt,
  output logic [1:0]   idx
);
  localparam int IW = N > 2 ? 2 : 1;
  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[IW'((int'(ptr) + k) % N)]) idx = 2'((int'(ptr) + k) % N);
    gnt = '0;
    gnt[IW'(idx)] = |req;
  end
endmodule

// File: rtl/cvt_fpi_sched.sv
// cvt_fpi_sched: round-robin issue of conversion requests with a stallable fixed-latency tag pipeline
module cvt_fpi_sched
  import cvt_fpi_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int LAT  = DEF_LAT,
  parameter int TAGW = DEF_TAGW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*OPW-1:0]  req_A,
  input  logic [NREQ*4-1:0]    req_fmt,
  input  logic [NREQ-1:0]      req_is32b,
  input  logic [NREQ*TAGW-1:0] req_tag,
  input  logic                 flush,
  output logic                 cv_en,
  output logic                 cv_clkEn,
  output logic [OPW-1:0]       cv_A,
  output logic [3:0]           cv_fmt,
  output logic                 cv_is32b,
  input  logic [RESW-1:0]      cv_res,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RESW-1:0]      out_res,
  output logic [TAGW-1:0]      out_tag,
  output logic [1:0]           out_port,
  output logic                 out_err,
  output logic                 busy
);
  logic [OPW-1:0]  a [4];
  logic [3:0]      f [4];
  logic [TAGW-1:0] t [4];
  logic [3:0]      s32;
  logic [NREQ-1:0] gnt;
  logic [1:0]      idx, ptr;
  logic            any, stall, acc, legal;
  stg_t            stg [LAT];
  logic [TAGW-1:0] tags [LAT];
  // requester slots padded to four so a 2-bit index always lands in range
  for (genvar g = 0; g < 4; g++) begin : g_un
    if (g < NREQ) begin : g_on
      assign a[g]   = req_A[g*OPW +: OPW];
      assign f[g]   = req_fmt[g*4 +: 4];
      assign t[g]   = req_tag[g*TAGW +: TAGW];
      assign s32[g] = req_is32b[g];
    end else begin : g_off
      assign a[g]   = '0;
      assign f[g]   = '0;
      assign t[g]   = '0;
      assign s32[g] = 1'b0;
    end
  end
  cvt_rr_arb #(.N(NREQ)) u_arb (.req(req_valid), .ptr(ptr), .gnt(gnt), .idx(idx));
  assign any       = |req_valid;
  assign stall     = out_valid & ~out_ready;
  assign acc       = any & ~stall & ~flush & ~rst;
  assign legal     = $onehot(f[idx]);
  assign req_ready = acc ? gnt : '0;
  assign cv_en     = acc & legal;
  assign cv_A      = any ? a[idx] : '0;
  assign cv_fmt    = any & legal ? f[idx] : '0;
  assign cv_is32b  = any & s32[idx];
  assign cv_clkEn  = ~stall;
  always_ff @(posedge clk)
    if (rst) ptr <= '0;
    else if (acc) ptr <= idx == 2'(NREQ - 1) ? '0 : idx + 2'd1;
  // flush and reset both override stall; tags ride along without reset
  always_ff @(posedge clk)
    if (rst | flush) begin
      for (int i = 0; i < LAT; i++) stg[i] <= '0;
    end else if (~stall) begin
      stg[0]  <= '{valid: acc, port: idx, err: ~legal};
      tags[0] <= t[idx];
      for (int i = 1; i < LAT; i++) begin
        stg[i]  <= stg[i-1];
        tags[i] <= tags[i-1];
      end
    end
  assign out_valid = stg[LAT-1].valid;
  assign out_port  = stg[LAT-1].port;
  assign out_err   = stg[LAT-1].err;
  assign out_tag   = tags[LAT-1];
  assign out_res   = out_err ? '0 : cv_res;
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < LAT; i++) busy = busy | stg[i].valid;
  end
endmodule

// File: tb/tb_cvt_fpi_sched.sv
// tb_cvt_fpi_sched: randomized and directed checks against an in-order latency scoreboard
module tb_cvt_fpi_sched;
  localparam int NREQ = 3;
  localparam int LAT  = 2;
  localparam int TAGW = 9;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, flush, out_ready;
  logic [NREQ-1:0] req_valid, req_ready, req_is32b;
  logic [81:0] a [NREQ];
  logic [3:0] fm [NREQ];
  logic [TAGW-1:0] tg [NREQ];
  logic [NREQ*82-1:0] req_A;
  logic [NREQ*4-1:0] req_fmt;
  logic [NREQ*TAGW-1:0] req_tag;
  logic cv_en, cv_clkEn, cv_is32b, out_valid, out_err, busy;
  logic [81:0] cv_A;
  logic [3:0] cv_fmt;
  logic [64:0] cv_res, out_res;
  logic [TAGW-1:0] out_tag;
  logic [1:0] out_port;
  logic [64:0] cu [LAT];
  int total = 0, bad = 0;

  always_comb begin
    req_A = '0;
    req_fmt = '0;
    req_tag = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_A[i*82 +: 82] = a[i];
      req_fmt[i*4 +: 4] = fm[i];
      req_tag[i*TAGW +: TAGW] = tg[i];
    end
  end

  cvt_fpi_sched #(.NREQ(NREQ), .LAT(LAT), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_A(req_A),
    .req_fmt(req_fmt), .req_is32b(req_is32b), .req_tag(req_tag), .flush(flush),
    .cv_en(cv_en), .cv_clkEn(cv_clkEn), .cv_A(cv_A), .cv_fmt(cv_fmt), .cv_is32b(cv_is32b),
    .cv_res(cv_res), .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_tag(out_tag), .out_port(out_port), .out_err(out_err), .busy(busy));

  function automatic logic [64:0] conv(logic [81:0] x, logic [3:0] f, logic s);
    return {s, x[63:0] ^ {x[81:64], 46'b0}} ^ {61'b0, f};
  endfunction

  // stand-in conversion unit: fixed LAT, frozen while clkEn is low
  always @(posedge clk)
    if (cv_clkEn) begin
      cu[0] <= cv_en ? conv(cv_A, cv_fmt, cv_is32b) : 65'b0;
      for (int i = 1; i < LAT; i++) cu[i] <= cu[i-1];
    end
  assign cv_res = cu[LAT-1];

  typedef struct {
    logic [TAGW-1:0] tag;
    int port;
    logic err;
    logic [64:0] res;
    int cnt;
  } item_t;
  item_t q[$];
  int ptr_m = 0;

  task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    int g;
    logic ov, st, acc, leg;
    logic [NREQ-1:0] er;
    #1;
    ov = q.size() > 0 && q[0].cnt == 0;
    st = ov & ~out_ready;
    chk("out_valid", 96'(out_valid), 96'(ov));
    if (ov) begin
      chk("out_tag", 96'(out_tag), 96'(q[0].tag));
      chk("out_port", 96'(out_port), 96'(q[0].port));
      chk("out_err", 96'(out_err), 96'(q[0].err));
      chk("out_res", 96'(out_res), 96'(q[0].res));
    end
    chk("busy", 96'(busy), 96'(q.size() > 0));
    chk("cv_clkEn", 96'(cv_clkEn), 96'(!st));
    g = -1;
    for (int k = 0; k < NREQ; k++)
      if (g < 0 && req_valid[(ptr_m + k) % NREQ]) g = (ptr_m + k) % NREQ;
    acc = g >= 0 && !st && !flush && !rst;
    leg = g >= 0 && $countones(fm[g]) == 1;
    er = '0;
    if (acc) er[g] = 1'b1;
    chk("req_ready", 96'(req_ready), 96'(er));
    chk("cv_en", 96'(cv_en), 96'(acc && leg));
    if (g >= 0) begin
      chk("cv_A", 96'(cv_A), 96'(a[g]));
      chk("cv_fmt", 96'(cv_fmt), 96'(leg ? fm[g] : 4'b0));
    end else chk("cv_A_idle", 96'(cv_A), 96'(0));
    if (rst) begin
      q.delete();
      ptr_m = 0;
    end else if (flush) q.delete();
    else if (!st) begin
      if (ov) void'(q.pop_front());
      foreach (q[i]) q[i].cnt--;
      if (acc) begin
        q.push_back('{tg[g], g, !leg, leg ? conv(a[g], fm[g], req_is32b[g]) : 65'b0, LAT - 1});
        ptr_m = (g + 1) % NREQ;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_req(input int i, input bit legal);
    a[i] = 82'({$urandom(), $urandom(), $urandom()});
    fm[i] = legal ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom());
    tg[i] = TAGW'($urandom());
    req_is32b[i] = 1'($urandom());
  endtask

  task automatic idle();
    req_valid = '0;
    flush = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    for (int i = 0; i < NREQ; i++) rnd_req(i, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    tick();
    rst = 1'b0;
    // single double-precision op from port 1
    rnd_req(1, 1'b1);
    fm[1] = 4'b0010;
    tg[1] = 9'h05;
    req_valid = 3'b010;
    tick();
    req_valid = '0;
    repeat (LAT + 2) tick();
    // all requesters continuously valid
    req_valid = '1;
    repeat (12) begin
      for (int i = 0; i < NREQ; i++) rnd_req(i, 1'b1);
      tick();
    end
    idle();
    repeat (LAT + 1) tick();
    // stall three cycles with full pipeline
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) rnd_req(i, 1'b1);
    repeat (LAT + 1) tick();
    out_ready = 1'b0;
    repeat (3) tick();
    out_ready = 1'b1;
    repeat (3) tick();
    idle();
    repeat (LAT + 2) tick();
    // illegal two-hot format
    rnd_req(0, 1'b1);
    fm[0] = 4'b0110;
    req_valid = 3'b001;
    tick();
    idle();
    repeat (LAT + 2) tick();
    // flush with two in flight while stalled
    req_valid = '1;
    repeat (2) tick();
    out_ready = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    idle();
    repeat (3) tick();
    // randomized traffic
    repeat (400) begin
      req_valid = NREQ'($urandom());
      for (int i = 0; i < NREQ; i++) rnd_req(i, $urandom_range(0, 9) != 0);
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 30) == 0;
      tick();
    end
    idle();
    repeat (LAT + 2) tick();
    // reset mid-operation
    req_valid = '1;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    repeat (LAT + 3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
